// File: rtl/liang_pkg.sv
// Shared types for the load/store stage: memory op codes, EX->LS and LS->WB payloads, FSM encoding.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package liang_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        MEM_NONE,
        LB,
        LH,
        LW,
        LBU,
        LHU,
        SB,
        SH,
        SW
    } mem_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] alu_result;
        mem_op_t         mem_op;
        logic [XLEN-1:0] store_data;
    } exToLs_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] rd_wdata;
        logic            misalign;
    } lsToWb_t;

    // Plain vector encoding so older blocks can compare against raw constants.
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_REQ  = 2'd1;
    localparam lsu_state_t LSU_WAIT = 2'd2;
    localparam lsu_state_t LSU_HOLD = 2'd3;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfword ops need an even address, word ops a 4-byte aligned one.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            LH, LHU, SH: mis = lo[0];
            LW, SW:      mis = |lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication + strobes, load lane select + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import liang_pkg::*;
#(
    parameter int XLEN = liang_pkg::XLEN
) (
    input  mem_op_t          st_op,
    input  logic [1:0]       st_addr_lo,
    input  logic [XLEN-1:0]  st_data,
    output logic [XLEN-1:0]  st_wdata,
    output logic [3:0]       st_wstrb,
    input  mem_op_t          ld_op,
    input  logic [1:0]       ld_addr_lo,
    input  logic [XLEN-1:0]  ld_rdata,
    output logic [XLEN-1:0]  ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate the store operand across every lane so the strobe alone selects the target bytes.
    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b0000;
        case (st_op)
            SB: begin
                st_wdata = {(XLEN/8){st_data[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            SH: begin
                st_wdata = {(XLEN/16){st_data[15:0]}};
                st_wstrb = 4'b0011 << st_addr_lo;
            end
            SW: begin
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wstrb = 4'b0000;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it to full width.
    always_comb begin
        ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        case (ld_op)
            LB:      ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LBU:     ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            LH:      ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            LHU:     ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/pipe_lsu.sv
// Load/store pipeline stage: passes ALU results through, issues one data-memory access per memory uop.
// Latency: 1 cycle for non-memory/misaligned uops; memory uops wait for grant (and rvalid for loads).
// Backpressure: ready only in IDLE or when the held result drains this cycle; held output is stable.
module pipe_lsu
    import liang_pkg::*;
#(
    parameter int XLEN = liang_pkg::XLEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  exToLs_t           exToLs_i,
    input  logic              ex_valid_i,
    output logic              ls_ready_o,
    output lsToWb_t           lsToWb_o,
    output logic              ls_valid_o,
    input  logic              wb_ready_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [3:0]        dmem_wstrb_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);

    lsu_state_t       state;
    lsToWb_t          out_q;
    mem_op_t          ld_op_q;
    logic [1:0]       ld_addr_lo_q;

    logic             accept;
    logic             in_is_mem;
    logic             in_store;
    logic             in_misalign;
    logic [XLEN-1:0]  st_wdata;
    logic [3:0]       st_wstrb;
    logic [XLEN-1:0]  ld_data;

    assign ls_ready_o  = (state == LSU_IDLE) || ((state == LSU_HOLD) && wb_ready_i);
    assign ls_valid_o  = (state == LSU_HOLD);
    assign lsToWb_o    = out_q;
    assign accept      = ex_valid_i && ls_ready_o;
    assign in_is_mem   = (exToLs_i.mem_op != MEM_NONE);
    assign in_store    = op_is_store(exToLs_i.mem_op);
    assign in_misalign = op_misaligned(exToLs_i.mem_op, exToLs_i.alu_result[1:0]);

    // Store lanes come from the incoming uop; load extraction uses the op latched at accept.
    lsu_align #(.XLEN(XLEN)) u_align (
        .st_op      (exToLs_i.mem_op),
        .st_addr_lo (exToLs_i.alu_result[1:0]),
        .st_data    (exToLs_i.store_data),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_op      (ld_op_q),
        .ld_addr_lo (ld_addr_lo_q),
        .ld_rdata   (dmem_rdata_i),
        .ld_data    (ld_data)
    );

    // Stage FSM: accept -> (REQ -> [WAIT] ->) HOLD -> drain; memory request fields are registered so they stay constant until grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= LSU_IDLE;
            out_q        <= '0;
            ld_op_q      <= MEM_NONE;
            ld_addr_lo_q <= 2'b00;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wstrb_o <= 4'b0000;
        end else if (accept) begin
            out_q.pc       <= exToLs_i.pc;
            out_q.rd       <= exToLs_i.rd;
            out_q.rd_wen   <= exToLs_i.rd_wen && !in_store && !in_misalign;
            out_q.rd_wdata <= exToLs_i.alu_result;
            out_q.misalign <= in_misalign;
            ld_op_q        <= exToLs_i.mem_op;
            ld_addr_lo_q   <= exToLs_i.alu_result[1:0];
            if (!in_is_mem || in_misalign) begin
                state <= LSU_HOLD;
            end else begin
                state        <= LSU_REQ;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= in_store;
                dmem_addr_o  <= {exToLs_i.alu_result[XLEN-1:2], 2'b00};
                dmem_wdata_o <= st_wdata;
                dmem_wstrb_o <= st_wstrb;
            end
        end else begin
            case (state)
                LSU_REQ: begin
                    // Any rvalid seen in the grant cycle is ignored: responses count only from WAIT.
                    if (dmem_gnt_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_wstrb_o <= 4'b0000;
                        state        <= dmem_we_o ? LSU_HOLD : LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid_i) begin
                        out_q.rd_wdata <= ld_data;
                        state          <= LSU_HOLD;
                    end
                end
                LSU_HOLD: begin
                    if (wb_ready_i) begin
                        state <= LSU_IDLE;
                    end
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_lsu.sv
// Bench for pipe_lsu: byte-level memory reference model, randomized handshakes and memory timing.
// Latency: checks 1-cycle turnaround for non-memory and misaligned uops.
// Backpressure: randomly stalls WB and checks held output stability and ready deassertion.
module tb_pipe_lsu;
    import liang_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    exToLs_t    ex_dat = '0;
    logic       ex_vld = 1'b0;
    logic       ls_rdy;
    lsToWb_t    wb_dat;
    logic       ls_vld;
    logic       wb_rdy = 1'b0;
    logic       dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0] dmem_wstrb;
    logic       dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    always #5 clk = ~clk;

    pipe_lsu #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .exToLs_i(ex_dat), .ex_valid_i(ex_vld), .ls_ready_o(ls_rdy),
        .lsToWb_o(wb_dat), .ls_valid_o(ls_vld), .wb_ready_i(wb_rdy),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_wstrb_o(dmem_wstrb), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    typedef struct {
        lsToWb_t o;
        bit      chk_data;
        bit      fixed_lat;
        int      acc_cyc;
        int      n_gnt;
    } exp_t;

    exToLs_t     issue_q[$];
    exp_t        exp_q[$];
    logic [7:0]  ref_mem[64];
    logic [31:0] bus_mem[16];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int wb_pct = 100, ex_pct = 100, wb_hold = 0, gnt_dly = 0, rv_dly = 1;
    bit rnd = 0;
    bit in_req = 0, rd_pend = 0, granted = 0;
    int req_wait = 0, rd_cnt = 0, grants = 0;
    logic [31:0] rd_word, cur_addr = '0;
    bit cur_we = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    bit          last_we;
    lsToWb_t     last_out, held;
    bit hold_pend = 0, seen_vld = 0;
    int first_vld_cyc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exToLs_t mk(input mem_op_t op, input logic [31:0] a, input logic [31:0] sd, input logic wen);
        exToLs_t u;
        u.pc         = $urandom;
        u.rd         = 5'($urandom_range(1, 31));
        u.rd_wen     = wen;
        u.alu_result = a;
        u.mem_op     = op;
        u.store_data = sd;
        return u;
    endfunction

    // Reference: memory seen as bytes, accesses as size-byte little-endian slices.
    function automatic void model(input exToLs_t u);
        exp_t e;
        int sz;
        logic [31:0] a, v;
        bit st, sgn;
        a = u.alu_result;
        e.o = '0;
        e.o.pc = u.pc;
        e.o.rd = u.rd;
        e.acc_cyc = cyc;
        e.chk_data = 1;
        e.fixed_lat = 0;
        e.n_gnt = 0;
        st  = (u.mem_op == SB) || (u.mem_op == SH) || (u.mem_op == SW);
        sgn = (u.mem_op == LB) || (u.mem_op == LH);
        case (u.mem_op)
            LB, LBU, SB: sz = 1;
            LH, LHU, SH: sz = 2;
            default:     sz = 4;
        endcase
        if (u.mem_op == MEM_NONE) begin
            e.o.rd_wen = u.rd_wen;
            e.o.rd_wdata = u.alu_result;
            e.fixed_lat = 1;
        end else if ((a % sz) != 0) begin
            e.o.misalign = 1;
            e.o.rd_wen = 0;
            e.chk_data = 0;
            e.fixed_lat = 1;
        end else begin
            e.n_gnt = 1;
            cur_addr = a & 32'hFFFF_FFFC;
            cur_we = st;
            if (st) begin
                for (int i = 0; i < sz; i++) ref_mem[(a + i) % 64] = u.store_data[8*i +: 8];
                e.o.rd_wen = 0;
                e.chk_data = 0;
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(a + i) % 64]) << (8 * i));
                if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                e.o.rd_wdata = v;
                e.o.rd_wen = u.rd_wen;
            end
        end
        exp_q.push_back(e);
    endfunction

    // One clock: drive inputs at negedge, then sample just after and score handshakes due at the next posedge.
    task automatic step(output bit acc, output bit fire);
        exp_t e;
        @(negedge clk);
        dmem_gnt = 0;
        dmem_rvalid = 0;
        dmem_rdata = $urandom;
        granted = 0;
        if (!rst) begin
            if (dmem_req) begin
                check("req_addr", dmem_addr, cur_addr);
                check("req_we", dmem_we, cur_we);
                if (!in_req) begin
                    in_req = 1;
                    req_wait = rnd ? $urandom_range(0, 3) : gnt_dly;
                end
                if (req_wait == 0) begin
                    dmem_gnt = 1;
                    in_req = 0;
                    grants++;
                    granted = 1;
                    last_addr = dmem_addr; last_we = dmem_we; last_wdata = dmem_wdata; last_wstrb = dmem_wstrb;
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_wstrb[b]) bus_mem[dmem_addr[5:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else begin
                        rd_pend = 1;
                        rd_word = bus_mem[dmem_addr[5:2]];
                        rd_cnt = rnd ? $urandom_range(1, 3) : rv_dly;
                        if (rnd && $urandom_range(0, 1) == 1) begin
                            dmem_rvalid = 1;
                            dmem_rdata = ~rd_word;
                        end
                    end
                end else begin
                    req_wait--;
                end
            end else begin
                in_req = 0;
                if (rd_pend) begin
                    if (rd_cnt <= 1) begin
                        dmem_rvalid = 1;
                        dmem_rdata = rd_word;
                        rd_pend = 0;
                    end else begin
                        rd_cnt--;
                    end
                end
            end
        end
        if (wb_hold > 0 && ls_vld) begin
            wb_rdy = 0;
            wb_hold--;
        end else begin
            wb_rdy = ($urandom_range(0, 99) < wb_pct);
        end
        if (issue_q.size() > 0 && (ex_vld || $urandom_range(0, 99) < ex_pct)) begin
            ex_vld = 1;
            ex_dat = issue_q[0];
        end else begin
            ex_vld = 0;
        end
        #1;
        cyc++;
        if (hold_pend) check("hold_stable", {ls_vld, wb_dat}, {1'b1, held});
        if (ls_vld && !wb_rdy) check("ready_in_hold", ls_rdy, 0);
        hold_pend = ls_vld && !wb_rdy;
        held = wb_dat;
        if (ls_vld && !seen_vld) begin
            seen_vld = 1;
            first_vld_cyc = cyc;
        end
        fire = ls_vld && wb_rdy;
        acc = ex_vld && ls_rdy;
        if (fire) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                last_out = wb_dat;
                check("pc", wb_dat.pc, e.o.pc);
                check("rd", wb_dat.rd, e.o.rd);
                check("rd_wen", wb_dat.rd_wen, e.o.rd_wen);
                check("misalign", wb_dat.misalign, e.o.misalign);
                if (e.chk_data) check("rd_wdata", wb_dat.rd_wdata, e.o.rd_wdata);
                check("grants", grants, e.n_gnt);
                if (e.fixed_lat) check("latency", first_vld_cyc - e.acc_cyc, 1);
            end
            grants = 0;
            seen_vld = 0;
        end
        if (acc) model(issue_q.pop_front());
    endtask

    task automatic drain(input int budget);
        bit a, f;
        int k;
        k = 0;
        while ((issue_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
            step(a, f);
            k++;
        end
        if (issue_q.size() > 0 || exp_q.size() > 0) check("drain_timeout", 1, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, ls_vld, 0);
        check({tag, "_ready"}, ls_rdy, 1);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_we"}, dmem_we, 0);
        check({tag, "_wstrb"}, dmem_wstrb, 0);
        check({tag, "_out"}, wb_dat, 0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic apply_reset(input int n);
        rst = 1;
        ex_vld = 0;
        wb_rdy = 0;
        #1;
        reset_checks("rst_async");
        issue_q.delete();
        exp_q.delete();
        hold_pend = 0; seen_vld = 0; grants = 0; in_req = 0;
        repeat (n) @(negedge clk);
        reset_checks("rst_hold");
        rst = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit a, f;
        int k;
        for (int w = 0; w < 16; w++) begin
            bus_mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = bus_mem[w][8*b +: 8];
        end
        @(negedge clk);
        apply_reset(3);

        // Non-memory uop: one-cycle turnaround, ALU result forwarded.
        issue_q.push_back(mk(MEM_NONE, 32'h1234, 32'h0, 1'b1));
        drain(50);
        check("add_wdata", last_out.rd_wdata, 32'h1234);
        check("add_wen", last_out.rd_wen, 1);

        // LB at byte 3 of a word, grant after two cycles, response two cycles after grant.
        bus_mem[0] = 32'h80FF_FFFF;
        ref_mem[0] = 8'hFF; ref_mem[1] = 8'hFF; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
        gnt_dly = 2; rv_dly = 2;
        issue_q.push_back(mk(LB, 32'h1003, 32'h0, 1'b1));
        drain(50);
        check("lb_wdata", last_out.rd_wdata, 32'hFFFF_FF80);
        check("lb_addr", last_addr, 32'h1000);

        // SH to the upper half: replicated data, upper strobes, no writeback.
        gnt_dly = 0; rv_dly = 1;
        issue_q.push_back(mk(SH, 32'h2002, 32'h0000_ABCD, 1'b1));
        drain(50);
        check("sh_wstrb", last_wstrb, 4'b1100);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_we", last_we, 1);
        check("sh_rd_wen", last_out.rd_wen, 0);

        // Misaligned LW: no request, flagged result next cycle.
        issue_q.push_back(mk(LW, 32'h1001, 32'h0, 1'b1));
        drain(50);
        check("lw_mis", last_out.misalign, 1);
        check("lw_mis_wen", last_out.rd_wen, 0);

        // WB stalls three cycles on a held result, then the next uop enters on the draining cycle.
        issue_q.push_back(mk(MEM_NONE, 32'h5555_0001, 32'h0, 1'b1));
        issue_q.push_back(mk(MEM_NONE, 32'h5555_0002, 32'h0, 1'b1));
        wb_hold = 3;
        k = 0;
        f = 0;
        while (!f && k < 50) begin
            step(a, f);
            k++;
        end
        check("b2b_fire", f, 1);
        check("b2b_accept", a, 1);
        drain(50);

        // Reset while waiting for a load response; the late response must not produce output.
        gnt_dly = 0; rv_dly = 6;
        issue_q.push_back(mk(LW, 32'h1004, 32'h0, 1'b1));
        k = 0;
        granted = 0;
        while (!granted && k < 50) begin
            step(a, f);
            k++;
        end
        check("wait_grant", granted, 1);
        step(a, f);
        #2;
        apply_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(a, f);
            check("late_rvalid_valid", ls_vld, 0);
            check("late_rvalid_ready", ls_rdy, 1);
            check("late_rvalid_req", dmem_req, 0);
        end
        rd_pend = 0;

        // Randomized traffic: mixed ops, random alignment, WB stalls and memory timing.
        rnd = 1; wb_pct = 70; ex_pct = 75;
        for (int i = 0; i < 400; i++) begin
            mem_op_t op;
            logic [31:0] ad;
            op = mem_op_t'($urandom_range(0, 8));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                case (op)
                    LH, LHU, SH: ad[0] = 1'b0;
                    LW, SW:      ad[1:0] = 2'b00;
                    default:     ad = ad;
                endcase
            end
            issue_q.push_back(mk(op, ad, $urandom, 1'($urandom_range(0, 1))));
        end
        drain(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
